// File: rtl/gcm_pkg.sv
`default_nettype none
// ============================================================================
// Module : gcm_pkg
// Brief  : Shared block/word sizes and FIFO entry type for the GCM egress path.
// Rev    : 1.0 - initial release
// ============================================================================
package gcm_pkg;

    localparam int GCM_BLK_BITS      = 128;
    localparam int GCM_WORD_BITS     = 32;
    localparam int GCM_WORDS_PER_BLK = GCM_BLK_BITS / GCM_WORD_BITS;

    typedef struct packed {
        logic                    last;
        logic [GCM_BLK_BITS-1:0] blk;
    } gcm_entry_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : sync_fifo
// Brief  : Generic single-clock FIFO; a write while full is taken only when a
//          read frees the slot in the same cycle.
// Rev    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_rd_ok;
    logic             w_wr_ok;

    assign full    = (r_count == c_DEPTH);
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    assign w_rd_ok = rd_en && !empty;
    assign w_wr_ok = wr_en && (!full || w_rd_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is left unreset; contents are only visible through valid pointers.
    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/gcm_out_sink.sv
`default_nettype none
// ============================================================================
// Module : gcm_out_sink
// Brief  : Buffers strobed GCM result blocks and serialises them MSW-first
//          onto a 32-bit AXI-Stream master, with feeder throttle and overflow.
// Rev    : 1.0 - initial release
// ============================================================================
module gcm_out_sink
    import gcm_pkg::*;
#(
    parameter int BLK_BITS   = 128,
    parameter int WORD_BITS  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int RESERVE    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [BLK_BITS-1:0]           in_blk,
    input  logic                          in_store,
    input  logic                          in_last,
    output logic                          in_allow,
    output logic [WORD_BITS-1:0]          m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tlast,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow
);

    localparam int             WORDS      = BLK_BITS / WORD_BITS;
    localparam int             IDX_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int             LW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(WORDS - 1);
    localparam logic [LW-1:0]  c_DEPTH    = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0]  c_RESERVE  = LW'(RESERVE);

    gcm_entry_t           w_wr_entry;
    gcm_entry_t           w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_xfer;
    logic                 w_pop;
    logic [LW-1:0]        w_free;
    logic [WORD_BITS-1:0] w_word;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_overflow;

    assign w_wr_entry.last = in_last;
    assign w_wr_entry.blk  = in_blk;

    sync_fifo #(
        .WIDTH (BLK_BITS + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (in_store),
        .wr_data (w_wr_entry),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (level)
    );

    assign m_tvalid = !w_empty;
    assign w_xfer   = m_tvalid && m_tready;
    assign w_pop    = w_xfer && (r_idx == c_IDX_LAST);

    // Word 0 is the most-significant slice to keep GCM big-endian byte order.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (r_idx == IDX_W'(i))
                w_word = w_head.blk[(WORDS-1-i)*WORD_BITS +: WORD_BITS];
        end
    end

    assign m_tdata  = m_tvalid ? w_word : '0;
    assign m_tlast  = m_tvalid && w_head.last && (r_idx == c_IDX_LAST);

    assign w_free   = c_DEPTH - level;
    assign in_allow = (w_free >= c_RESERVE);
    assign overflow = r_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop)       r_idx <= '0;
            else if (w_xfer) r_idx <= r_idx + IDX_W'(1);
            // A strobe into a full FIFO is lost unless this cycle frees a slot.
            if (in_store && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gcm_out_sink.sv
`default_nettype none
// ============================================================================
// Module : tb_gcm_out_sink
// Brief  : Directed and random checks of gcm_out_sink against a queue model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_gcm_out_sink;

    localparam int DEPTH   = 4;
    localparam int RESERVE = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] in_blk;
    logic         in_store;
    logic         in_last;
    logic         in_allow;
    logic [31:0]  m_tdata;
    logic         m_tvalid;
    logic         m_tready;
    logic         m_tlast;
    logic [2:0]   level;
    logic         overflow;

    gcm_out_sink #(
        .BLK_BITS   (128),
        .WORD_BITS  (32),
        .FIFO_DEPTH (DEPTH),
        .RESERVE    (RESERVE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_blk   (in_blk),
        .in_store (in_store),
        .in_last  (in_last),
        .in_allow (in_allow),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .level    (level),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of {last, blk}, word position, sticky overflow.
    logic [128:0] mq[$];
    int           m_idx;
    logic         m_ovf;

    logic [31:0]  obs_words[$];
    logic         obs_lasts[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [128:0] e, input int i);
        logic [127:0] b;
        b = e[127:0];
        return 32'(b >> (96 - 32 * i));
    endfunction

    task automatic model_reset();
        mq.delete();
        m_idx = 0;
        m_ovf = 1'b0;
    endtask

    task automatic step(input logic st, input logic [127:0] b, input logic l, input logic rdy);
        logic e_valid, e_last, e_allow, xfer, pop;
        logic [31:0] e_data;
        @(negedge clk);
        in_store = st; in_blk = b; in_last = l; m_tready = rdy;
        #1;
        e_valid = (mq.size() != 0);
        e_data  = e_valid ? word_of(mq[0], m_idx) : 32'h0;
        e_last  = e_valid && mq[0][128] && (m_idx == 3);
        e_allow = (DEPTH - mq.size()) >= RESERVE;
        chk("m_tvalid", 128'(m_tvalid), 128'(e_valid));
        chk("m_tdata",  128'(m_tdata),  128'(e_data));
        chk("m_tlast",  128'(m_tlast),  128'(e_last));
        chk("level",    128'(level),    128'(mq.size()));
        chk("in_allow", 128'(in_allow), 128'(e_allow));
        chk("overflow", 128'(overflow), 128'(m_ovf));
        if (m_tvalid && m_tready) begin
            obs_words.push_back(m_tdata);
            obs_lasts.push_back(m_tlast);
        end
        xfer = e_valid && rdy;
        pop  = xfer && (m_idx == 3);
        if (st) begin
            if (mq.size() < DEPTH || pop) mq.push_back({l, b});
            else m_ovf = 1'b1;
        end
        if (pop) begin
            void'(mq.pop_front());
            m_idx = 0;
        end else if (xfer) begin
            m_idx++;
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_store = 1'b0; in_last = 1'b0; m_tready = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    localparam logic [127:0] c_BLK  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] c_DROP = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

    initial begin
        logic [31:0] exp_w [4];
        logic [2:0]  lv;
        exp_w[0] = 32'h00112233; exp_w[1] = 32'h44556677;
        exp_w[2] = 32'h8899AABB; exp_w[3] = 32'hCCDDEEFF;
        reset = 1'b0; in_blk = '0; in_store = 1'b0; in_last = 1'b0; m_tready = 1'b0;
        do_reset();

        // Reset values
        chk("rst_tvalid", 128'(m_tvalid), 128'(0));
        chk("rst_level",  128'(level),    128'(0));
        chk("rst_allow",  128'(in_allow), 128'(1));

        // Single block, ready held high
        obs_words.delete(); obs_lasts.delete();
        step(1'b1, c_BLK, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1);
        chk("single_count", 128'(obs_words.size()), 128'(4));
        for (int i = 0; i < 4 && i < obs_words.size(); i++) begin
            chk("single_word", 128'(obs_words[i]), 128'(exp_w[i]));
            chk("single_last", 128'(obs_lasts[i]), 128'(i == 3));
        end
        chk("single_level", 128'(level), 128'(0));

        // Back-pressure: ready pattern 1,0,0,1,1,0,1
        obs_words.delete(); obs_lasts.delete();
        step(1'b1, c_BLK, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1); step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0); step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1); step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1); step(1'b0, '0, 1'b0, 1'b1);
        chk("bp_count", 128'(obs_words.size()), 128'(4));
        for (int i = 0; i < 4 && i < obs_words.size(); i++)
            chk("bp_word", 128'(obs_words[i]), 128'(exp_w[i]));

        // Burst fill with ready low, then overflow on a fifth strobe
        for (int i = 0; i < 4; i++) begin
            step(1'b1, {4{32'(i + 1)}}, 1'(i == 3), 1'b0);
            #1;
            lv = 3'(i + 1);
            chk("fill_level", 128'(level), 128'(lv));
            chk("fill_allow", 128'(in_allow), 128'(lv < 3));
        end
        step(1'b1, c_DROP, 1'b1, 1'b0);
        #1;
        chk("ovf_flag",  128'(overflow), 128'(1));
        chk("ovf_level", 128'(level),    128'(4));
        obs_words.delete(); obs_lasts.delete();
        for (int i = 0; i < 18; i++) step(1'b0, '0, 1'b0, 1'b1);
        chk("ovf_drain_count", 128'(obs_words.size()), 128'(16));
        foreach (obs_words[i]) chk("ovf_no_drop", 128'(obs_words[i] == 32'hDEADBEEF), 128'(0));

        // Full with a simultaneous pop at idx 3
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, {4{32'(i + 16)}}, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, c_BLK, 1'b1, 1'b1);
        #1;
        chk("fullpop_level", 128'(level),    128'(4));
        chk("fullpop_ovf",   128'(overflow), 128'(0));
        for (int i = 0; i < 17; i++) step(1'b0, '0, 1'b0, 1'b1);

        // Reset after two words of a block
        step(1'b1, c_BLK, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        do_reset();
        chk("midrst_tvalid", 128'(m_tvalid), 128'(0));
        chk("midrst_level",  128'(level),    128'(0));
        chk("midrst_allow",  128'(in_allow), 128'(1));
        step(1'b1, c_BLK, 1'b0, 1'b1);
        #1;
        chk("midrst_word0", 128'(m_tdata), 128'(32'h00112233));
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gcm_out_sink.md
# gcm_out_sink

Egress buffer for the GCM core's output stream. The core emits 128-bit result blocks (ciphertext/plaintext, then tag) on a single-cycle store strobe and has no back-pressure. This block captures every strobed block in a small FIFO and serialises it onto a 32-bit AXI-Stream master toward the DMA side. It also raises a throttle signal so the input feeder stops offering blocks before the FIFO can overflow.

## Interface
Parameters:
- BLK_BITS, 128, GCM block width; must equal 4 × WORD_BITS.
- WORD_BITS, 32, output stream word width.
- FIFO_DEPTH, 4, block entries; power of two, ≥ 2.
- RESERVE, 2, minimum free entries required for in_allow to be high.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- in_blk  in  BLK_BITS  result block from the GCM core.
- in_store  in  1  one-cycle strobe; capture in_blk this cycle.
- in_last  in  1  qualified by in_store; marks the final block of a message (the tag).
- in_allow  out  1  high when free entries ≥ RESERVE; gates the GCM input feeder's valid.
- m_tdata  out  WORD_BITS  output word.
- m_tvalid  out  1  output word valid.
- m_tready  in  1  downstream accept.
- m_tlast  out  1  last word of the message.
- level  out  clog2(FIFO_DEPTH)+1  occupied entries.
- overflow  out  1  sticky error: a strobed block was dropped.

## Operation
- Each FIFO entry stores {last, blk}, written on in_store when not full.
- Read side: the head entry is split into WORD_BITS words, most-significant first (blk[127:96], then blk[95:64], and so on). This preserves GCM big-endian byte order.
- Word index counter idx runs 0..3:
  - A word transfers when m_tvalid && m_tready; idx then increments.
  - On the transfer at idx == 3, the head entry pops and idx returns to 0.
- m_tvalid = (level != 0). m_tdata = head word[idx], forced to 0 when m_tvalid is low.
- m_tlast = head.last && idx == 3. A message ends on the final word of its tag block.
- in_allow = (FIFO_DEPTH − level) ≥ RESERVE, combinational from registered level.
- Store while full:
  - With a pop in the same cycle: the store is accepted and level is unchanged.
  - Without a pop: the block is dropped and overflow is set. overflow clears only on reset.
- Store and pop in the same cycle when not full: level is unchanged.
- in_last without in_store is ignored.
- Reset mid-operation:
  - Pointers, idx and level clear; buffered data is discarded.
  - A partially sent block is abandoned without m_tlast.
  - The downstream consumer is reset by the same domain reset.

## Timing
- Reset values: m_tvalid 0, m_tdata 0, m_tlast 0, level 0, in_allow 1, overflow 0.
- Latency: in_store at edge N gives m_tvalid high after edge N (visible in cycle N+1), first word on m_tdata.
- Throughput: one word per cycle with m_tready held high. A 128-bit block drains in 4 cycles; there is no bubble between blocks.
- m_tdata, m_tlast and m_tvalid must hold stable while m_tvalid && !m_tready. Only a transfer advances idx.
- level and overflow update on the clock edge after the triggering event.
- in_allow drops in the same cycle level reaches FIFO_DEPTH − RESERVE + 1. The feeder therefore has RESERVE − 1 blocks of slack for blocks already inside the GCM pipeline.

## Structure
- gcm_pkg holds:
  - GCM_BLK_BITS = 128.
  - GCM_WORDS_PER_BLK = GCM_BLK_BITS / WORD_BITS.
  - The entry typedef {logic last; logic [GCM_BLK_BITS-1:0] blk}.
- Sub-module sync_fifo: generic single-clock FIFO.
  - Provides write/read enables, full, empty and count.
  - Write is accepted while full only if a read happens in the same cycle.
- gcm_out_sink contains sync_fifo plus the idx serialiser, in_allow compare and overflow flag.

## Test plan
- Single block: in_store with in_blk = 0x00112233_44556677_8899AABB_CCDDEEFF and in_last = 1, m_tready = 1.
  - Required: words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on consecutive cycles.
  - m_tlast high only on 0xCCDDEEFF; level back to 0.
- Back-pressure: same block with m_tready toggling 1,0,0,1,1,0,1.
  - Required: each word held stable while stalled; exactly 4 transfers in order.
- Burst fill: 4 strobes on consecutive cycles with m_tready = 0.
  - Required: level 1, 2, 3, 4; in_allow falls when level hits 3; overflow stays 0.
- Overflow: fifth strobe while full, no pop.
  - Required: overflow = 1, level stays 4, dropped block never appears on the output.
- Full with simultaneous pop: FIFO full, m_tready = 1, idx = 3, store in the same cycle.
  - Required: block accepted, level stays 4, overflow stays 0.
- Reset mid-block: reset asserted after 2 words of a block are transferred.
  - Required: m_tvalid = 0, level = 0 and in_allow = 1 on the next cycle.
  - A new block afterwards starts from word 0.
